// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_pkg
// Purpose  : Shared definitions for the system-bus arbiter: bus command
//            encodings, the request FSM state type and the index-width
//            helper used to size the downstream tag.
// Revision : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

    // Bus command encodings shared by the sysbus family of blocks.
    localparam logic [1:0] READ   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
    localparam logic [1:0] MEMORY = 2'd2;

    // Width of the per-client outstanding counters (limit is at most 15).
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        REQ_IDLE = 1'b0,
        REQ_BUSY = 1'b1
    } req_state_e;

    // Bits needed to encode an index in 0..n-1; never less than one bit so
    // that the client index field always exists in the downstream tag.
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first eligible
//            index at or after the pointer, wrapping modulo N_CLIENTS.
// Ports    : i_eligible - one bit per client
//            i_rr_ptr   - search start index (0..N_CLIENTS-1)
//            o_idx      - selected index (0 when nothing is eligible)
//            o_found    - at least one client is eligible
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import sysbus_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int IDX_W     = clog2_w(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] i_eligible,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_found
);

    int               w_pos;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down to the pointer itself so the last
    // hit written is the one closest to the pointer.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            w_pos = int'(i_rr_ptr) + k;
            if (w_pos >= N_CLIENTS) begin
                w_pos = w_pos - N_CLIENTS;
            end
            w_cand = IDX_W'(w_pos);
            if (i_eligible[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_arbiter
// Purpose  : N-client to one-downstream bus arbiter. Round-robin grants a
//            whole request transaction to one client, prefixes the client
//            index onto the downstream tag, limits per-client outstanding
//            requests and routes responses back by the tag index.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            c_req/c_reqtag/c_reqcyc/c_reqack     - client request ports
//            c_resp/c_resptag/c_respcyc/c_respack - client response ports
//            m_req/m_reqtag/m_reqcyc/m_reqack     - downstream request
//            m_resp/m_resptag/m_respcyc/m_respack - downstream response
//            tag_err             - sticky bad-index / counter-underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter  int DATA_WIDTH      = 64,
    parameter  int TAG_WIDTH       = 1,
    parameter  int N_CLIENTS       = 4,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int IDX_W           = clog2_w(N_CLIENTS),
    localparam int DTAG_W          = TAG_WIDTH + IDX_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_CLIENTS-1:0][DATA_WIDTH-1:0] c_req,
    input  logic [N_CLIENTS-1:0][TAG_WIDTH-1:0]  c_reqtag,
    input  logic [N_CLIENTS-1:0]                 c_reqcyc,
    output logic [N_CLIENTS-1:0]                 c_reqack,
    output logic [N_CLIENTS-1:0][DATA_WIDTH-1:0] c_resp,
    output logic [N_CLIENTS-1:0][TAG_WIDTH-1:0]  c_resptag,
    output logic [N_CLIENTS-1:0]                 c_respcyc,
    input  logic [N_CLIENTS-1:0]                 c_respack,
    output logic [DATA_WIDTH-1:0]                m_req,
    output logic [DTAG_W-1:0]                    m_reqtag,
    output logic                                 m_reqcyc,
    input  logic                                 m_reqack,
    input  logic [DATA_WIDTH-1:0]                m_resp,
    input  logic [DTAG_W-1:0]                    m_resptag,
    input  logic                                 m_respcyc,
    output logic                                 m_respack,
    output logic                                 tag_err
);

    req_state_e                         state_q, state_d;
    logic [IDX_W-1:0]                   grant_q, grant_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic                               beat_seen_q, beat_seen_d;
    logic [N_CLIENTS-1:0][CNT_W-1:0]    outstanding_q, outstanding_d;
    logic                               tag_err_q, tag_err_d;
    logic                               resp_live_q, resp_live_d;
    logic [IDX_W-1:0]                   resp_idx_q, resp_idx_d;

    logic [N_CLIENTS-1:0] w_eligible;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_found;
    logic                 w_gnt_cyc;
    logic                 w_busy;
    logic                 w_req_done;
    logic [IDX_W-1:0]     w_rsp_idx;
    logic                 w_rsp_idx_ok;
    logic                 w_resp_end;
    logic                 w_underflow;
    logic                 w_inc_hit;
    logic                 w_dec_hit;

    // ---------------------------------------------------------------- arbiter
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_eligible[i] = c_reqcyc[i] &&
                            (outstanding_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    rr_pick #(
        .N_CLIENTS (N_CLIENTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_rr_ptr   (rr_ptr_q),
        .o_idx      (w_pick_idx),
        .o_found    (w_pick_found)
    );

    assign w_gnt_cyc = c_reqcyc[grant_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_seen_d = beat_seen_q;
        w_req_done  = 1'b0;
        case (state_q)
            REQ_IDLE: begin
                if (w_pick_found) begin
                    state_d     = REQ_BUSY;
                    grant_d     = w_pick_idx;
                    beat_seen_d = 1'b0;
                end
            end
            REQ_BUSY: begin
                if (!w_gnt_cyc) begin
                    state_d     = REQ_IDLE;
                    rr_ptr_d    = (grant_q == IDX_W'(N_CLIENTS - 1)) ?
                                  '0 : grant_q + IDX_W'(1);
                    // Zero-beat aborts never reached downstream, so they
                    // must not consume an outstanding slot.
                    w_req_done  = beat_seen_q;
                    beat_seen_d = 1'b0;
                end else if (m_reqack) begin
                    beat_seen_d = 1'b1;
                end
            end
            default: begin
                state_d = REQ_IDLE;
            end
        endcase
    end

    // Request outputs are forced quiet while reset is high so an in-flight
    // transaction is cut off in the reset cycle itself.
    assign w_busy   = (state_q == REQ_BUSY) && !reset;
    assign m_req    = c_req[grant_q];
    assign m_reqtag = {grant_q, c_reqtag[grant_q]};
    assign m_reqcyc = w_busy && w_gnt_cyc;

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            c_reqack[i] = w_busy && (grant_q == IDX_W'(i)) && m_reqack;
        end
    end

    // ----------------------------------------------------------- response path
    assign w_rsp_idx    = m_resptag[DTAG_W-1:TAG_WIDTH];
    assign w_rsp_idx_ok = ({1'b0, w_rsp_idx} < (IDX_W + 1)'(N_CLIENTS));

    always_comb begin
        // An out-of-range index has no client to stall it, so it is sunk.
        m_respack = m_respcyc && !w_rsp_idx_ok;
        for (int i = 0; i < N_CLIENTS; i++) begin
            c_respcyc[i] = 1'b0;
            c_resp[i]    = '0;
            c_resptag[i] = '0;
            if (w_rsp_idx_ok && (w_rsp_idx == IDX_W'(i))) begin
                c_respcyc[i] = m_respcyc;
                c_resp[i]    = m_resp;
                c_resptag[i] = m_resptag[TAG_WIDTH-1:0];
                m_respack    = c_respack[i];
            end
        end
    end

    // A response transaction ends the first cycle its valid, in-range run is
    // no longer continuing with the same index.
    assign resp_live_d = m_respcyc && w_rsp_idx_ok;
    assign resp_idx_d  = w_rsp_idx;
    assign w_resp_end  = resp_live_q &&
                         !(m_respcyc && w_rsp_idx_ok && (w_rsp_idx == resp_idx_q));

    // ----------------------------------------------------- outstanding counters
    always_comb begin
        outstanding_d = outstanding_q;
        w_underflow   = 1'b0;
        w_inc_hit     = 1'b0;
        w_dec_hit     = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_inc_hit = w_req_done && (grant_q == IDX_W'(i));
            w_dec_hit = w_resp_end && (resp_idx_q == IDX_W'(i));
            if (w_inc_hit && !w_dec_hit) begin
                outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
            end else if (w_dec_hit && !w_inc_hit) begin
                if (outstanding_q[i] == '0) begin
                    w_underflow = 1'b1;
                end else begin
                    outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
                end
            end
        end
    end

    assign tag_err_d = tag_err_q || (m_respcyc && !w_rsp_idx_ok) || w_underflow;
    assign tag_err   = tag_err_q;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= REQ_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            beat_seen_q   <= 1'b0;
            outstanding_q <= '0;
            tag_err_q     <= 1'b0;
            resp_live_q   <= 1'b0;
            resp_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_seen_q   <= beat_seen_d;
            outstanding_q <= outstanding_d;
            tag_err_q     <= tag_err_d;
            resp_live_q   <= resp_live_d;
            resp_idx_q    <= resp_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysbus_arbiter
// Purpose  : Directed self-checking bench for sysbus_arbiter (N=4 instance)
//            plus an N=3 instance for the out-of-range index case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int TW  = 1;
    localparam int DTW = 3;

    logic clk;
    logic reset;
    logic reset3;

    logic [N-1:0][DW-1:0] c_req;
    logic [N-1:0][TW-1:0] c_reqtag;
    logic [N-1:0]         c_reqcyc;
    logic [N-1:0]         c_reqack;
    logic [N-1:0][DW-1:0] c_resp;
    logic [N-1:0][TW-1:0] c_resptag;
    logic [N-1:0]         c_respcyc;
    logic [N-1:0]         c_respack;
    logic [DW-1:0]        m_req;
    logic [DTW-1:0]       m_reqtag;
    logic                 m_reqcyc;
    logic                 m_reqack;
    logic [DW-1:0]        m_resp;
    logic [DTW-1:0]       m_resptag;
    logic                 m_respcyc;
    logic                 m_respack;
    logic                 tag_err;

    logic [2:0][7:0] c_req3;
    logic [2:0][0:0] c_reqtag3;
    logic [2:0]      c_reqcyc3;
    logic [2:0]      c_reqack3;
    logic [2:0][7:0] c_resp3;
    logic [2:0][0:0] c_resptag3;
    logic [2:0]      c_respcyc3;
    logic [2:0]      c_respack3;
    logic [7:0]      m_req3;
    logic [2:0]      m_reqtag3;
    logic            m_reqcyc3;
    logic            m_reqack3;
    logic [7:0]      m_resp3;
    logic [2:0]      m_resptag3;
    logic            m_respcyc3;
    logic            m_respack3;
    logic            tag_err3;

    sysbus_arbiter dut (
        .clk (clk), .reset (reset),
        .c_req (c_req), .c_reqtag (c_reqtag), .c_reqcyc (c_reqcyc), .c_reqack (c_reqack),
        .c_resp (c_resp), .c_resptag (c_resptag), .c_respcyc (c_respcyc), .c_respack (c_respack),
        .m_req (m_req), .m_reqtag (m_reqtag), .m_reqcyc (m_reqcyc), .m_reqack (m_reqack),
        .m_resp (m_resp), .m_resptag (m_resptag), .m_respcyc (m_respcyc), .m_respack (m_respack),
        .tag_err (tag_err)
    );

    sysbus_arbiter #(.DATA_WIDTH (8), .TAG_WIDTH (1), .N_CLIENTS (3), .MAX_OUTSTANDING (2)) dut3 (
        .clk (clk), .reset (reset3),
        .c_req (c_req3), .c_reqtag (c_reqtag3), .c_reqcyc (c_reqcyc3), .c_reqack (c_reqack3),
        .c_resp (c_resp3), .c_resptag (c_resptag3), .c_respcyc (c_respcyc3), .c_respack (c_respack3),
        .m_req (m_req3), .m_reqtag (m_reqtag3), .m_reqcyc (m_reqcyc3), .m_reqack (m_reqack3),
        .m_resp (m_resp3), .m_resptag (m_resptag3), .m_respcyc (m_respcyc3), .m_respack (m_respack3),
        .tag_err (tag_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  tag;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Drives one request transaction from client cl; expected downstream
    // beats are queued up front and popped as the DUT accepts them.
    task automatic send(input int cl, input logic tg, input int nb,
                        input logic [63:0] base, output int lat);
        exp_t e;
        int   beat;
        int   cyc;
        beat = 0;
        cyc  = 0;
        lat  = -1;
        for (int b = 0; b < nb; b++) begin
            e.tag  = {2'(cl), tg};
            e.data = base + 64'(b);
            sb.push_back(e);
        end
        c_reqtag[cl] = tg;
        c_req[cl]    = base;
        c_reqcyc[cl] = 1'b1;
        while (beat < nb && cyc < 20) begin
            settle();
            if (m_reqcyc && m_reqack) begin
                e = sb.pop_front();
                chk("req_tag", 64'(m_reqtag), 64'(e.tag));
                chk("req_data", m_req, e.data);
                chk("req_ack_vec", 64'(c_reqack), 64'(1 << cl));
                if (lat < 0) lat = cyc;
                beat++;
            end
            tick();
            cyc++;
            c_req[cl] = base + 64'(beat);
        end
        chk("req_beats", 64'(beat), 64'(nb));
        c_reqcyc[cl] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cycles;
        int beat;
        int last_acc;
        int ngr;
        int g;
        int acc_client;
        int raise_client;
        int cnt [4];
        exp_t e;

        reset = 1'b1;  reset3 = 1'b1;
        c_req = '0;  c_reqtag = '0;  c_reqcyc = '0;  c_respack = '0;
        m_reqack = 1'b0;  m_resp = '0;  m_resptag = '0;  m_respcyc = 1'b0;
        c_req3 = '0;  c_reqtag3 = '0;  c_reqcyc3 = '0;  c_respack3 = '0;
        m_reqack3 = 1'b0;  m_resp3 = '0;  m_resptag3 = '0;  m_respcyc3 = 1'b0;

        // Reset state
        tick();  tick();
        settle();
        chk("rst_m_reqcyc", 64'(m_reqcyc), 0);
        chk("rst_reqack", 64'(c_reqack), 0);
        chk("rst_tag_err", 64'(tag_err), 0);
        tick();
        reset = 1'b0;  reset3 = 1'b0;
        settle();
        chk("rst_outstanding", 64'(dut.outstanding_q), 0);
        tick();

        // Single client: client 2, tag 1, three beats
        m_reqack = 1'b1;
        send(2, 1'b1, 3, 64'hA000, lat);
        chk("t1_latency", 64'(lat), 1);
        tick();
        settle();
        chk("t1_outstanding2", 64'(dut.outstanding_q[2]), 1);
        chk("t1_idle_reqcyc", 64'(m_reqcyc), 0);

        // Client 1 one beat, then a 4-beat response to {1,0} with toggling ack
        tick();
        send(1, 1'b0, 1, 64'hB000, lat);
        chk("t2_latency", 64'(lat), 1);
        tick();
        settle();
        chk("t2_outstanding1", 64'(dut.outstanding_q[1]), 1);
        tick();
        for (int b = 0; b < 4; b++) begin
            e.tag  = 3'b000;
            e.data = 64'hC000 + 64'(b);
            sb.push_back(e);
        end
        m_resptag = 3'b010;  m_respcyc = 1'b1;  m_resp = 64'hC000;
        beat = 0;  cycles = 0;
        while (beat < 4 && cycles < 20) begin
            c_respack[1] = cycles[0];
            settle();
            chk("rsp_cyc_vec", 64'(c_respcyc), 64'h2);
            chk("rsp_ack", 64'(m_respack), 64'(c_respack[1]));
            if (c_respack[1]) begin
                e = sb.pop_front();
                chk("rsp_data", c_resp[1], e.data);
                chk("rsp_tag", 64'(c_resptag[1]), 64'(e.tag));
                beat++;
            end
            if (cycles == 2) chk("rsp_mid_outstanding", 64'(dut.outstanding_q[1]), 1);
            tick();
            cycles++;
            m_resp = 64'hC000 + 64'(beat);
        end
        chk("rsp_beats", 64'(beat), 4);
        m_respcyc = 1'b0;  c_respack = '0;
        tick();
        settle();
        chk("rsp_outstanding1", 64'(dut.outstanding_q[1]), 0);
        chk("rsp_tag_err", 64'(tag_err), 0);

        // Reset pulse before round robin
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Round robin: clients 0, 1, 3 request continuously
        gq = '{0, 1, 3, 0, 1, 3};
        cnt = '{0, 0, 0, 0};
        last_acc = -1;  ngr = 0;  cycles = 0;  raise_client = -1;
        c_reqcyc = 4'b1011;
        while (ngr < 6 && cycles < 60) begin
            settle();
            acc_client = -1;
            if (m_reqcyc && m_reqack) begin
                g = int'(m_reqtag[2:1]);
                chk("rr_grant", 64'(g), 64'(gq.pop_front()));
                if (last_acc >= 0) chk("rr_spacing", 64'(cycles - last_acc), 3);
                last_acc = cycles;
                cnt[g]++;
                ngr++;
                acc_client = g;
            end
            tick();
            cycles++;
            if (raise_client >= 0) begin
                c_reqcyc[raise_client] = 1'b1;
                raise_client = -1;
            end
            if (acc_client >= 0) begin
                c_reqcyc[acc_client] = 1'b0;
                if (cnt[acc_client] < 2) raise_client = acc_client;
            end
        end
        chk("rr_count", 64'(ngr), 6);
        tick();
        settle();
        chk("rr_outstanding", 64'(dut.outstanding_q), 64'h2022);

        // Outstanding limit: client 0 at 2 is held off until a response ends
        tick();
        c_reqcyc[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("lim_blocked", 64'(m_reqcyc), 0);
            tick();
        end
        m_resptag = 3'b000;  m_resp = 64'hD000;  m_respcyc = 1'b1;  c_respack[0] = 1'b1;
        settle();
        chk("lim_rsp_route", 64'(c_respcyc), 64'h1);
        chk("lim_rsp_ack", 64'(m_respack), 1);
        chk("lim_rsp_data", c_resp[0], 64'hD000);
        tick();
        m_respcyc = 1'b0;  c_respack = '0;
        settle();
        chk("lim_end_wait", 64'(m_reqcyc), 0);
        tick();
        settle();
        chk("lim_arb_wait", 64'(m_reqcyc), 0);
        tick();
        settle();
        chk("lim_granted", 64'(m_reqcyc), 1);
        chk("lim_grant_tag", 64'(m_reqtag), 64'h0);
        tick();
        c_reqcyc[0] = 1'b0;
        tick();

        // Reset during beat 2 of a 4-beat transaction from client 2
        c_req[2] = 64'hE000;  c_reqtag[2] = 1'b0;  c_reqcyc[2] = 1'b1;
        settle();
        chk("mr_idle_arb", 64'(m_reqcyc), 0);
        tick();
        settle();
        chk("mr_beat1", 64'(m_reqcyc), 1);
        chk("mr_beat1_tag", 64'(m_reqtag), 64'h4);
        tick();
        c_req[2] = 64'hE001;
        reset = 1'b1;
        settle();
        chk("mr_reset_reqcyc", 64'(m_reqcyc), 0);
        chk("mr_reset_reqack", 64'(c_reqack), 0);
        tick();
        reset = 1'b0;
        c_reqcyc = 4'b1001;
        settle();
        chk("mr_post_idle", 64'(m_reqcyc), 0);
        chk("mr_post_outstanding", 64'(dut.outstanding_q), 0);
        tick();
        settle();
        chk("mr_first_cyc", 64'(m_reqcyc), 1);
        chk("mr_first_grant", 64'(m_reqtag[2:1]), 0);
        tick();
        c_reqcyc = '0;
        tick();

        // Response to a client with nothing outstanding saturates and flags
        m_resptag = 3'b010;  m_respcyc = 1'b1;  c_respack[1] = 1'b1;
        settle();
        chk("uf_route", 64'(c_respcyc), 64'h2);
        tick();
        m_respcyc = 1'b0;  c_respack = '0;
        settle();
        chk("uf_pre", 64'(tag_err), 0);
        tick();
        settle();
        chk("uf_tag_err", 64'(tag_err), 1);
        chk("uf_sat", 64'(dut.outstanding_q[1]), 0);
        chk("uf_other", 64'(dut.outstanding_q[0]), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("uf_cleared", 64'(tag_err), 0);

        // Out-of-range index on the 3-client instance
        tick();
        m_resptag3 = 3'b110;  m_respcyc3 = 1'b1;  c_respack3 = '0;
        settle();
        chk("bad_sink", 64'(m_respack3), 1);
        chk("bad_no_cyc", 64'(c_respcyc3), 0);
        tick();
        m_respcyc3 = 1'b0;
        settle();
        chk("bad_flag", 64'(tag_err3), 1);
        repeat (3) tick();
        settle();
        chk("bad_held", 64'(tag_err3), 1);
        chk("bad_main_clean", 64'(tag_err), 0);
        tick();
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        settle();
        chk("bad_reset", 64'(tag_err3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
